tile_buffer_ctrl: RTL and testbench
===================================

Name: tile_buffer_ctrl

Overview:
Tile-granular on-chip buffer controller. It sits directly downstream of the load execution stage and absorbs its vector tile writes and matrix tile writes. Each write is appended at a per-buffer write pointer. Compute stages read tiles back by (buffer id, tile index) with fixed 1-cycle latency. A per-buffer clear rewinds the pointer at the start of each new LOAD.

Parameters:
DATA_WIDTH, 8, element width in bits
TILE_WIDTH, 256, tile width in bits
TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile
NUM_VEC_BUFS, 16, number of vector buffers (ids 0..NUM_VEC_BUFS-1)
VEC_DEPTH, 32, tiles per vector buffer
NUM_MAT_BUFS, 2, number of matrix buffers (own id space, 0..NUM_MAT_BUFS-1)
MAT_DEPTH, 1024, tiles per matrix buffer

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  pulse: rewind write pointer/count of (clear_is_mat, clear_buffer_id)
clear_is_mat  in  1  0 = vector bank, 1 = matrix bank
clear_buffer_id  in  5  buffer to clear
vec_write_enable  in  1  append vec_write_tile to vector buffer
vec_write_buffer_id  in  5  target vector buffer
vec_write_tile  in  TILE_ELEMS x DATA_WIDTH signed  tile payload, element 0 first
mat_write_enable  in  1  append mat_write_tile to matrix buffer
mat_write_buffer_id  in  5  target matrix buffer
mat_write_tile  in  TILE_WIDTH  packed tile payload
vec_read_enable  in  1  read request
vec_read_buffer_id  in  5  vector buffer to read
vec_read_tile_idx  in  $clog2(VEC_DEPTH)  tile index
vec_read_valid  out  1  read data valid
vec_read_tile  out  TILE_ELEMS x DATA_WIDTH signed  read data
vec_read_count  out  $clog2(VEC_DEPTH)+1  fill count of the buffer read
mat_read_enable  in  1  read request
mat_read_buffer_id  in  5  matrix buffer to read
mat_read_tile_idx  in  $clog2(MAT_DEPTH)  tile index
mat_read_valid  out  1  read data valid
mat_read_tile  out  TILE_WIDTH  read data
mat_read_count  out  $clog2(MAT_DEPTH)+1  fill count of the buffer read
overflow_err  out  1  sticky: a write was dropped
read_err  out  1  1-cycle pulse, aligned with *_read_valid, on an invalid read

Behaviour:
- Reset (rst_n low, asynchronous):
  - All write counts = 0.
  - All outputs = 0: valids, tiles, counts, overflow_err, read_err.
  - Storage contents are not reset; they are irrelevant because count = 0.
- Write, per bank, on an enable cycle:
  - The tile is stored at index count[id], then count[id] increments.
  - At most one vector write and one matrix write per cycle; the two banks are independent.
- Dropped writes:
  - A write with id out of range, or with count[id] == DEPTH, is dropped and sets overflow_err.
  - overflow_err stays set until rst_n; clear does not clear it.
- Clear:
  - count[id] = 0 on the next edge.
  - A clear with id out of range is ignored and does not set an error.
- Clear and write to the same buffer in the same cycle: the clear applies first, the tile lands at index 0, and count becomes 1.
- Clear to buffer A with write to buffer B in the same cycle: both take effect.
- Read timing:
  - A request in cycle N gives *_read_valid = 1 in cycle N+1, with the tile and the count of that buffer.
  - Valid is a 1-cycle pulse; one request per cycle per bank is supported, fully pipelined.
  - The tile and count outputs hold their last value when valid is low.
- Read of a location written in the same cycle returns the old contents (read-before-write); the count returned is also the pre-write count.
- Invalid read: id out of range, or idx >= count[id].
  - valid still asserts, with tile = 0 and read_err = 1.
  - Count is 0 for an out-of-range id, otherwise count[id].
- Vector and matrix read_err sources are ORed.
- Element packing: vector element i maps to the same storage bits as mat_write_tile[i*DATA_WIDTH +: DATA_WIDTH].
- Reset asserted mid-stream:
  - Any pending read valid is cancelled.
  - All counts return to 0, so every buffer is empty after reset.

Test Plan:
- Reset, clear vec buf 3, write 3 tiles (element 0 = 1, 2, 3), read idx 0..2 back-to-back -> valid in cycles N+1..N+3, element 0 = 1, 2, 3, count = 3, read_err = 0.
- Fill vec buf 0 with 32 tiles, then write a 33rd -> dropped; overflow_err = 1 and stays 1 after clear; reading idx 31 returns the 32nd tile.
- Same cycle: clear and write tile 0xAA.. to vec buf 5, which already holds 4 tiles -> count = 1; read idx 0 = 0xAA..; read idx 1 -> tile 0, read_err = 1.
- Mat buf 1: write 1024 tiles with mat_write_tile = index -> read idx 1023 returns 1023, count = 1024; read mat id 7 -> tile 0, count 0, read_err = 1.
- Read vec buf 2 idx 0 in the same cycle as the first write to it (count 0) -> read_err = 1, count 0; the next-cycle read returns the written tile.
- Assert rst_n low while a read request is in flight -> vec_read_valid is not asserted after release, all counts read back as 0, overflow_err = 0.

Source files
------------

// File: rtl/tile_buffer_ctrl.sv
// Tile buffer controller: per-buffer append writes into vector/matrix banks, indexed reads with 1-cycle latency.
// No backpressure: writes that do not fit are dropped and flagged, and invalid reads return a zero tile with read_err.
module tile_buffer_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_WIDTH   = 256,
  parameter int TILE_ELEMS   = TILE_WIDTH / DATA_WIDTH,
  parameter int NUM_VEC_BUFS = 16,
  parameter int VEC_DEPTH    = 32,
  parameter int NUM_MAT_BUFS = 2,
  parameter int MAT_DEPTH    = 1024,
  localparam int VIDX_W = $clog2(VEC_DEPTH),
  localparam int MIDX_W = $clog2(MAT_DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clear,
  input  logic                                          clear_is_mat,
  input  logic [4:0]                                    clear_buffer_id,
  input  logic                                          vec_write_enable,
  input  logic [4:0]                                    vec_write_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]  vec_write_tile,
  input  logic                                          mat_write_enable,
  input  logic [4:0]                                    mat_write_buffer_id,
  input  logic [TILE_WIDTH-1:0]                         mat_write_tile,
  input  logic                                          vec_read_enable,
  input  logic [4:0]                                    vec_read_buffer_id,
  input  logic [VIDX_W-1:0]                             vec_read_tile_idx,
  output logic                                          vec_read_valid,
  output logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]  vec_read_tile,
  output logic [VIDX_W:0]                               vec_read_count,
  input  logic                                          mat_read_enable,
  input  logic [4:0]                                    mat_read_buffer_id,
  input  logic [MIDX_W-1:0]                             mat_read_tile_idx,
  output logic                                          mat_read_valid,
  output logic [TILE_WIDTH-1:0]                         mat_read_tile,
  output logic [MIDX_W:0]                               mat_read_count,
  output logic                                          overflow_err,
  output logic                                          read_err
);

  localparam int VCNT_W = VIDX_W + 1;
  localparam int MCNT_W = MIDX_W + 1;
  localparam int VID_W  = (NUM_VEC_BUFS > 1) ? $clog2(NUM_VEC_BUFS) : 1;
  localparam int MID_W  = (NUM_MAT_BUFS > 1) ? $clog2(NUM_MAT_BUFS) : 1;
  localparam logic [5:0] VEC_IDS = 6'(NUM_VEC_BUFS);
  localparam logic [5:0] MAT_IDS = 6'(NUM_MAT_BUFS);
  localparam logic [VCNT_W-1:0] VEC_FULL = VCNT_W'(VEC_DEPTH);
  localparam logic [MCNT_W-1:0] MAT_FULL = MCNT_W'(MAT_DEPTH);

  logic [TILE_WIDTH-1:0] vec_mem [2**(VID_W+VIDX_W)];
  logic [TILE_WIDTH-1:0] mat_mem [2**(MID_W+MIDX_W)];
  logic [VCNT_W-1:0]     vec_cnt [NUM_VEC_BUFS];
  logic [MCNT_W-1:0]     mat_cnt [NUM_MAT_BUFS];

  logic [VID_W-1:0]  vec_wr_sel, vec_rd_sel;
  logic [MID_W-1:0]  mat_wr_sel, mat_rd_sel;
  logic              vec_clr, vec_wr_ok, vec_rd_id_ok, vec_rd_hit;
  logic              mat_clr, mat_wr_ok, mat_rd_id_ok, mat_rd_hit;
  logic [VCNT_W-1:0] vec_wr_pos, vec_rd_cnt;
  logic [MCNT_W-1:0] mat_wr_pos, mat_rd_cnt;

  assign vec_wr_sel = vec_write_buffer_id[VID_W-1:0];
  assign vec_rd_sel = vec_read_buffer_id[VID_W-1:0];
  assign mat_wr_sel = mat_write_buffer_id[MID_W-1:0];
  assign mat_rd_sel = mat_read_buffer_id[MID_W-1:0];

  assign vec_clr = clear && !clear_is_mat && ({1'b0, clear_buffer_id} < VEC_IDS);
  assign mat_clr = clear &&  clear_is_mat && ({1'b0, clear_buffer_id} < MAT_IDS);

  // A same-cycle clear of the target buffer rewinds before the append lands.
  assign vec_wr_pos = (vec_clr && clear_buffer_id == vec_write_buffer_id) ? '0 : vec_cnt[vec_wr_sel];
  assign mat_wr_pos = (mat_clr && clear_buffer_id == mat_write_buffer_id) ? '0 : mat_cnt[mat_wr_sel];
  assign vec_wr_ok  = vec_write_enable && ({1'b0, vec_write_buffer_id} < VEC_IDS) && (vec_wr_pos < VEC_FULL);
  assign mat_wr_ok  = mat_write_enable && ({1'b0, mat_write_buffer_id} < MAT_IDS) && (mat_wr_pos < MAT_FULL);

  assign vec_rd_id_ok = {1'b0, vec_read_buffer_id} < VEC_IDS;
  assign mat_rd_id_ok = {1'b0, mat_read_buffer_id} < MAT_IDS;
  assign vec_rd_cnt   = vec_rd_id_ok ? vec_cnt[vec_rd_sel] : '0;
  assign mat_rd_cnt   = mat_rd_id_ok ? mat_cnt[mat_rd_sel] : '0;
  assign vec_rd_hit   = vec_rd_id_ok && ({1'b0, vec_read_tile_idx} < vec_rd_cnt);
  assign mat_rd_hit   = mat_rd_id_ok && ({1'b0, mat_read_tile_idx} < mat_rd_cnt);

  always_ff @(posedge clk) begin
    if (vec_wr_ok) vec_mem[{vec_wr_sel, vec_wr_pos[VIDX_W-1:0]}] <= vec_write_tile;
    if (mat_wr_ok) mat_mem[{mat_wr_sel, mat_wr_pos[MIDX_W-1:0]}] <= mat_write_tile;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_VEC_BUFS; b++) vec_cnt[b] <= '0;
      for (int b = 0; b < NUM_MAT_BUFS; b++) mat_cnt[b] <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_VEC_BUFS; b++) begin
        if (vec_clr && clear_buffer_id == 5'(b)) vec_cnt[b] <= '0;
        if (vec_wr_ok && vec_write_buffer_id == 5'(b)) vec_cnt[b] <= vec_wr_pos + VCNT_W'(1);
      end
      for (int b = 0; b < NUM_MAT_BUFS; b++) begin
        if (mat_clr && clear_buffer_id == 5'(b)) mat_cnt[b] <= '0;
        if (mat_wr_ok && mat_write_buffer_id == 5'(b)) mat_cnt[b] <= mat_wr_pos + MCNT_W'(1);
      end
      if ((vec_write_enable && !vec_wr_ok) || (mat_write_enable && !mat_wr_ok)) overflow_err <= 1'b1;
    end
  end

  // Reads sample storage and counts before this edge's writes take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_read_valid <= 1'b0;
      vec_read_tile  <= '0;
      vec_read_count <= '0;
      mat_read_valid <= 1'b0;
      mat_read_tile  <= '0;
      mat_read_count <= '0;
      read_err       <= 1'b0;
    end else begin
      vec_read_valid <= vec_read_enable;
      mat_read_valid <= mat_read_enable;
      if (vec_read_enable) begin
        vec_read_tile  <= vec_rd_hit ? vec_mem[{vec_rd_sel, vec_read_tile_idx}] : '0;
        vec_read_count <= vec_rd_cnt;
      end
      if (mat_read_enable) begin
        mat_read_tile  <= mat_rd_hit ? mat_mem[{mat_rd_sel, mat_read_tile_idx}] : '0;
        mat_read_count <= mat_rd_cnt;
      end
      read_err <= (vec_read_enable && !vec_rd_hit) || (mat_read_enable && !mat_rd_hit);
    end
  end

endmodule

// File: tb/tb_tile_buffer_ctrl.sv
// Bench for tile_buffer_ctrl: directed scenarios plus random traffic checked against a queue-per-buffer model.
module tb_tile_buffer_ctrl;
  localparam int DW = 8, TW = 256, TE = 32, NV = 16, VD = 32, NM = 2, MD = 1024;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  clear, clear_is_mat;
  logic [4:0]            clear_buffer_id;
  logic                  vec_write_enable, mat_write_enable, vec_read_enable, mat_read_enable;
  logic [4:0]            vec_write_buffer_id, mat_write_buffer_id, vec_read_buffer_id, mat_read_buffer_id;
  logic [TE-1:0][DW-1:0] vec_write_tile, vec_read_tile;
  logic [TW-1:0]         mat_write_tile, mat_read_tile;
  logic [4:0]            vec_read_tile_idx;
  logic [9:0]            mat_read_tile_idx;
  logic                  vec_read_valid, mat_read_valid, overflow_err, read_err;
  logic [5:0]            vec_read_count;
  logic [10:0]           mat_read_count;

  tile_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .clear(clear), .clear_is_mat(clear_is_mat), .clear_buffer_id(clear_buffer_id),
    .vec_write_enable(vec_write_enable), .vec_write_buffer_id(vec_write_buffer_id), .vec_write_tile(vec_write_tile),
    .mat_write_enable(mat_write_enable), .mat_write_buffer_id(mat_write_buffer_id), .mat_write_tile(mat_write_tile),
    .vec_read_enable(vec_read_enable), .vec_read_buffer_id(vec_read_buffer_id), .vec_read_tile_idx(vec_read_tile_idx),
    .vec_read_valid(vec_read_valid), .vec_read_tile(vec_read_tile), .vec_read_count(vec_read_count),
    .mat_read_enable(mat_read_enable), .mat_read_buffer_id(mat_read_buffer_id), .mat_read_tile_idx(mat_read_tile_idx),
    .mat_read_valid(mat_read_valid), .mat_read_tile(mat_read_tile), .mat_read_count(mat_read_count),
    .overflow_err(overflow_err), .read_err(read_err)
  );

  // Reference model: each buffer is simply the ordered list of tiles appended since its last clear.
  logic [TW-1:0] vq [NV][$];
  logic [TW-1:0] mq [NM][$];
  logic          m_ovf, e_vv, e_mv, e_err;
  logic [TW-1:0] e_vt, e_mt;
  int            e_vc, e_mc;
  int            checks = 0, errors = 0;

  task automatic chk(string tag, logic [TW-1:0] obs, logic [TW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    clear = 1'b0; clear_is_mat = 1'b0; clear_buffer_id = '0;
    vec_write_enable = 1'b0; vec_write_buffer_id = '0; vec_write_tile = '0;
    mat_write_enable = 1'b0; mat_write_buffer_id = '0; mat_write_tile = '0;
    vec_read_enable = 1'b0; vec_read_buffer_id = '0; vec_read_tile_idx = '0;
    mat_read_enable = 1'b0; mat_read_buffer_id = '0; mat_read_tile_idx = '0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NV; b++) vq[b].delete();
    for (int b = 0; b < NM; b++) mq[b].delete();
    m_ovf = 1'b0; e_vv = 1'b0; e_mv = 1'b0; e_err = 1'b0;
    e_vt = '0; e_mt = '0; e_vc = 0; e_mc = 0;
  endtask

  task automatic check_outputs(string pfx);
    chk({pfx, "vec_valid"}, TW'(vec_read_valid), TW'(e_vv));
    chk({pfx, "vec_tile"}, vec_read_tile, e_vt);
    chk({pfx, "vec_count"}, TW'(vec_read_count), TW'(e_vc));
    chk({pfx, "mat_valid"}, TW'(mat_read_valid), TW'(e_mv));
    chk({pfx, "mat_tile"}, mat_read_tile, e_mt);
    chk({pfx, "mat_count"}, TW'(mat_read_count), TW'(e_mc));
    chk({pfx, "read_err"}, TW'(read_err), TW'(e_err));
    chk({pfx, "overflow_err"}, TW'(overflow_err), TW'(m_ovf));
  endtask

  // One clock: predict from pre-edge model state, apply the edge's updates, then compare.
  task automatic cycle();
    int  id, idx;
    bit  verr = 1'b0, merr = 1'b0;
    e_vv = vec_read_enable;
    e_mv = mat_read_enable;
    if (vec_read_enable) begin
      id = int'(vec_read_buffer_id); idx = int'(vec_read_tile_idx);
      e_vc = 0; e_vt = '0; verr = 1'b1;
      if (id < NV) begin
        e_vc = vq[id].size();
        if (idx < e_vc) begin e_vt = vq[id][idx]; verr = 1'b0; end
      end
    end
    if (mat_read_enable) begin
      id = int'(mat_read_buffer_id); idx = int'(mat_read_tile_idx);
      e_mc = 0; e_mt = '0; merr = 1'b1;
      if (id < NM) begin
        e_mc = mq[id].size();
        if (idx < e_mc) begin e_mt = mq[id][idx]; merr = 1'b0; end
      end
    end
    e_err = verr | merr;
    if (clear) begin
      id = int'(clear_buffer_id);
      if (clear_is_mat) begin if (id < NM) mq[id].delete(); end
      else begin if (id < NV) vq[id].delete(); end
    end
    if (vec_write_enable) begin
      id = int'(vec_write_buffer_id);
      if (id >= NV) m_ovf = 1'b1;
      else if (vq[id].size() >= VD) m_ovf = 1'b1;
      else vq[id].push_back(vec_write_tile);
    end
    if (mat_write_enable) begin
      id = int'(mat_write_buffer_id);
      if (id >= NM) m_ovf = 1'b1;
      else if (mq[id].size() >= MD) m_ovf = 1'b1;
      else mq[id].push_back(mat_write_tile);
    end
    @(posedge clk); #1;
    check_outputs("");
    idle_inputs();
  endtask

  // Reset asserted before the coming edge; any read requested for this cycle must not produce valid.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_outputs("rst_");
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
  endtask

  function automatic logic [TW-1:0] rnd_tile();
    logic [TW-1:0] t;
    for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom();
    return t;
  endfunction

  function automatic logic [4:0] pick_id(int n);
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, n - 1));
  endfunction

  task automatic random_phase(int n_cycles);
    for (int n = 0; n < n_cycles; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        clear = 1'b1; clear_is_mat = ($urandom_range(0, 3) == 0); clear_buffer_id = 5'($urandom_range(0, 19));
      end
      if ($urandom_range(0, 1) == 1) begin
        vec_write_enable = 1'b1; vec_write_buffer_id = pick_id(6); vec_write_tile = rnd_tile();
      end
      if ($urandom_range(0, 1) == 1) begin
        vec_read_enable = 1'b1; vec_read_buffer_id = pick_id(6);
        vec_read_tile_idx = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 2) == 0) begin
        mat_write_enable = 1'b1; mat_write_buffer_id = 5'($urandom_range(0, 2)); mat_write_tile = rnd_tile();
      end
      if ($urandom_range(0, 1) == 1) begin
        mat_read_enable = 1'b1; mat_read_buffer_id = 5'($urandom_range(0, 2));
        mat_read_tile_idx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40));
      end
      cycle();
    end
  endtask

  initial begin
    idle_inputs();
    do_reset();
    cycle();

    // Clear vec 3, append three tiles, read them back-to-back.
    clear = 1'b1; clear_buffer_id = 5'd3; cycle();
    for (int k = 1; k <= 3; k++) begin
      vec_write_enable = 1'b1; vec_write_buffer_id = 5'd3; vec_write_tile = TW'(k); cycle();
    end
    for (int k = 0; k < 3; k++) begin
      vec_read_enable = 1'b1; vec_read_buffer_id = 5'd3; vec_read_tile_idx = 5'(k); cycle();
    end
    cycle();

    // Fill vec 0 past capacity, read the last slot, then clear: overflow must persist.
    for (int k = 0; k <= VD; k++) begin
      vec_write_enable = 1'b1; vec_write_buffer_id = 5'd0; vec_write_tile = rnd_tile(); cycle();
    end
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd0; vec_read_tile_idx = 5'd31; cycle();
    clear = 1'b1; clear_buffer_id = 5'd0; cycle();
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd0; vec_read_tile_idx = 5'd0; cycle();

    // Vec 5 with four tiles, then clear and write in the same cycle.
    for (int k = 0; k < 4; k++) begin
      vec_write_enable = 1'b1; vec_write_buffer_id = 5'd5; vec_write_tile = rnd_tile(); cycle();
    end
    clear = 1'b1; clear_buffer_id = 5'd5;
    vec_write_enable = 1'b1; vec_write_buffer_id = 5'd5; vec_write_tile = {TE{8'hAA}}; cycle();
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd5; vec_read_tile_idx = 5'd0; cycle();
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd5; vec_read_tile_idx = 5'd1; cycle();

    // Fill mat 1 completely, read last entry, read an out-of-range matrix id.
    for (int k = 0; k < MD; k++) begin
      mat_write_enable = 1'b1; mat_write_buffer_id = 5'd1; mat_write_tile = TW'(k); cycle();
    end
    mat_read_enable = 1'b1; mat_read_buffer_id = 5'd1; mat_read_tile_idx = 10'd1023; cycle();
    mat_read_enable = 1'b1; mat_read_buffer_id = 5'd7; mat_read_tile_idx = 10'd0; cycle();
    cycle();

    // Read vec 2 idx 0 in the same cycle as its first write, then again.
    clear = 1'b1; clear_buffer_id = 5'd2; cycle();
    vec_write_enable = 1'b1; vec_write_buffer_id = 5'd2; vec_write_tile = rnd_tile();
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd2; vec_read_tile_idx = 5'd0; cycle();
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd2; vec_read_tile_idx = 5'd0; cycle();
    cycle();

    random_phase(400);

    // Reset with a read request pending, then every buffer must read back empty.
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd3; vec_read_tile_idx = 5'd0;
    mat_read_enable = 1'b1; mat_read_buffer_id = 5'd1; mat_read_tile_idx = 10'd0;
    do_reset();
    cycle();
    for (int b = 0; b <= NV; b++) begin
      vec_read_enable = 1'b1; vec_read_buffer_id = 5'(b); vec_read_tile_idx = 5'd0;
      if (b <= NM) begin
        mat_read_enable = 1'b1; mat_read_buffer_id = 5'(b); mat_read_tile_idx = 10'd0;
      end
      cycle();
    end

    random_phase(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
